// File: rtl/grid_pkg.sv
// grid_pkg
//   Shared definitions for the life-grid scan-out path: grid geometry,
//   grid/row container types, the scan FSM state encoding and a small
//   width helper used to size counters safely.
package grid_pkg;

  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;
  localparam int GRID_BITS = GRID_ROWS * GRID_COLS;

  typedef logic [GRID_BITS-1:0] grid_t;
  typedef logic [GRID_COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } scan_state_t;

  // Counter width for a modulo-n count; never returns zero so a counter
  // declared from it is always at least one bit wide.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_shifter.sv
// row_shifter
//   Serialises one row of the frame into the column driver chain.
//   A one-cycle load pulse captures the row and starts shifting; each bit
//   occupies CLK_DIV cycles, sclk low for the first half and high for the
//   second half, so sdata only ever moves while sclk is low. The MSB
//   (column COLS-1) goes out first.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset
//     load       one-cycle pulse: capture load_data and start shifting
//     load_data  row to serialise
//     sclk       shift clock to the driver chain (low when idle)
//     sdata      serial column data (low when idle)
//     done       high on the final cycle of the last bit
module row_shifter
  import grid_pkg::*;
#(
  parameter int COLS    = GRID_COLS,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [COLS-1:0] load_data,
  output logic            sclk,
  output logic            sdata,
  output logic            done
);

  localparam int DW = safe_clog2(CLK_DIV);
  localparam int BW = safe_clog2(COLS);

  logic [COLS-1:0] shreg;
  logic            active;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            div_last;
  logic            bit_last;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BW'(COLS - 1));

  // Prescaler and shift register. The register advances on the same edge
  // that ends a bit period, which is also the edge where sclk falls, so
  // the new bit appears at the start of the next sclk-low half.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (div_last) begin
        div_cnt <= '0;
        shreg   <= {shreg[COLS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_last) begin
          active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded straight from registered state; both are forced
  // low whenever no row is being shifted.
  assign sclk  = active && (div_cnt >= DW'(CLK_DIV / 2));
  assign sdata = active && shreg[COLS-1];
  assign done  = active && div_last && bit_last;

endmodule

// File: rtl/grid_scanout.sv
// grid_scanout
//   Scans the life grid onto a row-multiplexed LED matrix. Each new
//   generation lands in a shadow register; the shadow is copied into the
//   frame buffer only when row 0 is loaded, so a displayed frame never
//   mixes two generations. Every row is shifted out, latched, then held
//   on the display for HOLD_CYCLES cycles.
//
//   Ports:
//     clk         system clock
//     reset       asynchronous active-low reset
//     grid_in     grid from the datapath, row r at [COLS*r +: COLS]
//     grid_valid  one-cycle strobe: grid_in holds a new generation
//     enable      level; high scans frames continuously
//     sclk        shift clock to the column driver chain
//     sdata       serial column data, column COLS-1 first
//     latch       one-cycle strobe moving the shifted row to the drivers
//     row_sel     currently displayed row
//     oe_n        active-low display enable
//     frame_done  one-cycle pulse after the last row's hold
module grid_scanout
  import grid_pkg::*;
#(
  parameter int COLS        = GRID_COLS,
  parameter int ROWS        = GRID_ROWS,
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS*COLS-1:0]     grid_in,
  input  logic                     grid_valid,
  input  logic                     enable,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     latch,
  output logic [$clog2(ROWS)-1:0]  row_sel,
  output logic                     oe_n,
  output logic                     frame_done
);

  localparam int RW = $clog2(ROWS);
  localparam int HW = safe_clog2(HOLD_CYCLES);

  scan_state_t          state;
  scan_state_t          state_next;
  logic [RW-1:0]        row_idx;
  logic [ROWS*COLS-1:0] shadow;
  logic [ROWS*COLS-1:0] frame;
  logic [ROWS*COLS-1:0] frame_src;
  logic [COLS-1:0]      load_row;
  logic [HW-1:0]        hold_cnt;
  logic                 hold_last;
  logic                 last_row;
  logic                 shift_load;
  logic                 shift_done;

  assign hold_last = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign last_row  = (row_idx == RW'(ROWS - 1));

  // A strobe arriving in the very cycle row 0 is loaded must win over the
  // shadow, otherwise that generation would slip a whole frame.
  assign frame_src = grid_valid ? grid_in : shadow;
  assign load_row  = (row_idx == '0) ? frame_src[COLS-1:0]
                                     : frame[int'(row_idx)*COLS +: COLS];

  row_shifter #(
    .COLS    (COLS),
    .CLK_DIV (CLK_DIV)
  ) u_row_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (shift_load),
    .load_data (load_row),
    .sclk      (sclk),
    .sdata     (sdata),
    .done      (shift_done)
  );

  // Scan state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode. enable is only looked at in IDLE and at
  // the end of the last row's hold, so dropping it mid-frame still lets
  // the frame finish.
  always_comb begin
    state_next = state;
    shift_load = 1'b0;
    latch      = 1'b0;
    oe_n       = 1'b1;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        shift_load = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (shift_done) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        latch      = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        oe_n = 1'b0;
        if (hold_last) begin
          state_next = (!last_row || enable) ? LOAD : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Buffers, row bookkeeping and the frame_done pulse. row_sel moves on the
  // edge that enters LATCH so it changes together with the latched data,
  // and it keeps its last value while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow     <= '0;
      frame      <= '0;
      row_idx    <= '0;
      row_sel    <= '0;
      hold_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (grid_valid) begin
        shadow <= grid_in;
      end
      if (state == LOAD && row_idx == '0) begin
        frame <= frame_src;
      end
      if (state == SHIFT && shift_done) begin
        row_sel <= row_idx;
      end
      if (state == LATCH) begin
        hold_cnt <= '0;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == IDLE) begin
        row_idx <= '0;
      end else if (state == HOLD && hold_last) begin
        row_idx <= last_row ? '0 : row_idx + 1'b1;
      end
      frame_done <= (state == HOLD) && hold_last && last_row;
    end
  end

endmodule

// File: tb/tb_grid_scanout.sv
// tb_grid_scanout
//   Directed bench for grid_scanout with CLK_DIV=2 and HOLD_CYCLES=4,
//   giving a 38-cycle row and a 608-cycle frame. A monitor rebuilds each
//   shifted row from sclk/sdata and records it, with row_sel, whenever
//   latch pulses; directed phases then compare those records against
//   hand-computed rows and cycle positions.
module tb_grid_scanout;

  localparam int COLS        = 16;
  localparam int ROWS        = 16;
  localparam int CLK_DIV     = 2;
  localparam int HOLD_CYCLES = 4;

  // Hand-computed timing, counted in clock edges after reset release
  // (release edge number 0): LOAD on edge 1, 32 shift cycles, LATCH
  // entered on edge 34; last row ends its hold on edge 1 + 16*38 = 609.
  localparam int FIRST_LATCH   = 34;
  localparam int FRAME_DONE_AT = 609;
  localparam int FRAME_CYCLES  = 608;

  logic                  clk;
  logic                  reset;
  logic [ROWS*COLS-1:0]  grid_in;
  logic                  grid_valid;
  logic                  enable;
  logic                  sclk;
  logic                  sdata;
  logic                  latch;
  logic [3:0]            row_sel;
  logic                  oe_n;
  logic                  frame_done;

  int compare_count;
  int mismatch_count;

  logic [15:0] rows_seen [0:511];
  logic [3:0]  sels_seen [0:511];
  int          latch_cycles [0:511];
  int          fd_cycles [0:63];
  int          latch_count;
  int          fd_count;
  int          cycle_count;
  logic [15:0] cap;
  logic        prev_sclk;

  grid_scanout #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .CLK_DIV     (CLK_DIV),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .grid_in    (grid_in),
    .grid_valid (grid_valid),
    .enable     (enable),
    .sclk       (sclk),
    .sdata      (sdata),
    .latch      (latch),
    .row_sel    (row_sel),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge: shift sdata in on every sclk rise, record
  // the rebuilt row and row_sel at each latch, and timestamp frame_done.
  initial begin
    latch_count = 0;
    fd_count    = 0;
    cycle_count = 0;
    cap         = '0;
    prev_sclk   = 1'b0;
  end

  always @(negedge clk) begin
    cycle_count = cycle_count + 1;
    if (sclk && !prev_sclk) begin
      cap = {cap[14:0], sdata};
    end
    prev_sclk = sclk;
    if (latch) begin
      rows_seen[latch_count % 512]    = cap;
      sels_seen[latch_count % 512]    = row_sel;
      latch_cycles[latch_count % 512] = cycle_count;
      latch_count = latch_count + 1;
    end
    if (frame_done) begin
      fd_cycles[fd_count % 64] = cycle_count;
      fd_count = fd_count + 1;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compare_count = compare_count + 1;
    if (actual !== expected) begin
      mismatch_count = mismatch_count + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One-cycle grid_valid strobe, launched just after a falling edge so the
  // next rising edge sees it exactly once.
  task automatic applyStimulus(input logic [ROWS*COLS-1:0] data);
    grid_in    = data;
    grid_valid = 1'b1;
    @(negedge clk);
    #1;
    grid_valid = 1'b0;
  endtask

  task automatic waitLatches(input int target, input string tag);
    for (int i = 0; i < 2000 && latch_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput(tag, 64'(latch_count), 64'(target));
  endtask

  task automatic waitFrameDone(input int target, input string tag);
    for (int i = 0; i < 2000 && fd_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput(tag, 64'(fd_count), 64'(target));
  endtask

  // Compare one recorded frame: row 0, row 1 and every other row against
  // the given patterns, and row_sel against the row number.
  task automatic checkFrame(input int first, input logic [15:0] r0,
                            input logic [15:0] r1, input logic [15:0] rest,
                            input string name);
    logic [15:0] exp_row;
    for (int r = 0; r < ROWS; r++) begin
      exp_row = (r == 0) ? r0 : ((r == 1) ? r1 : rest);
      checkOutput($sformatf("%s_row%0d_data", name, r),
                  64'(rows_seen[(first + r) % 512]), 64'(exp_row));
      checkOutput($sformatf("%s_row%0d_sel", name, r),
                  64'(sels_seen[(first + r) % 512]), 64'(r));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d mismatched so far",
             mismatch_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          rel;
    int          base;
    logic [8:0]  outs;
    logic [ROWS*COLS-1:0] glider;
    logic [ROWS*COLS-1:0] ones;
    logic [ROWS*COLS-1:0] single;

    compare_count  = 0;
    mismatch_count = 0;
    glider = 256'h0000e00000;
    ones   = '1;
    single = 256'h1;

    reset      = 1'b1;
    enable     = 1'b1;
    grid_valid = 1'b0;
    grid_in    = '0;
    #2;
    reset = 1'b0;

    $display("[TB] phase 1: reset, first frame, enable drop at row 3");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      outs = {oe_n, sclk, latch, frame_done, sdata, row_sel};
      checkOutput($sformatf("reset_outputs_%0d", i), 64'(outs), 64'(9'b1_0000_0000));
    end
    rel   = cycle_count;
    reset = 1'b1;

    waitLatches(4, "p1_reach_row3");
    enable = 1'b0;
    waitFrameDone(1, "p1_frame_done");
    checkOutput("p1_first_latch_cycle", 64'(latch_cycles[0]), 64'(rel + FIRST_LATCH));
    checkOutput("p1_frame_done_cycle", 64'(fd_cycles[0]), 64'(rel + FRAME_DONE_AT));
    checkOutput("p1_latch_count", 64'(latch_count), 64'(16));
    checkFrame(0, 16'h0000, 16'h0000, 16'h0000, "p1");
    repeat (100) @(negedge clk);
    #1;
    checkOutput("idle_latch_count", 64'(latch_count), 64'(16));
    checkOutput("idle_fd_count", 64'(fd_count), 64'(1));
    checkOutput("idle_oe_n", 64'(oe_n), 64'(1));
    checkOutput("idle_row_sel_held", 64'(row_sel), 64'(15));

    $display("[TB] phase 2: glider, tearing, same-cycle strobe");
    applyStimulus(glider);
    grid_in = '0;
    enable  = 1'b1;
    base    = latch_count;
    waitLatches(base + 4, "p2_glider_row3");
    applyStimulus(ones);
    waitLatches(base + 16, "p2_glider_end");
    checkFrame(base, 16'h0000, 16'h00E0, 16'h0000, "glider");
    waitLatches(base + 24, "p2_ones_row7");
    applyStimulus('0);
    waitLatches(base + 32, "p2_ones_end");
    checkFrame(base + 16, 16'hFFFF, 16'hFFFF, 16'hFFFF, "tear_ones");
    waitLatches(base + 48, "p2_zeros_end");
    checkFrame(base + 32, 16'h0000, 16'h0000, 16'h0000, "tear_next");
    checkOutput("frame_period", 64'(fd_cycles[2] - fd_cycles[1]), 64'(FRAME_CYCLES));
    for (int i = 0; i < 40 && !frame_done; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("bypass_done_seen", 64'(frame_done), 64'(1));
    applyStimulus(single);
    waitLatches(base + 64, "p2_bypass_end");
    checkFrame(base + 48, 16'h0001, 16'h0000, 16'h0000, "bypass");

    $display("[TB] phase 3: asynchronous reset during row 5 shift");
    waitLatches(base + 69, "p3_reach_row4");
    repeat (9) @(negedge clk);
    #1;
    checkOutput("pre_reset_sclk", 64'(sclk), 64'(1));
    checkOutput("pre_reset_row_sel", 64'(row_sel), 64'(4));
    #2;
    reset = 1'b0;
    #1;
    outs = {oe_n, sclk, latch, frame_done, sdata, row_sel};
    checkOutput("async_reset_outputs", 64'(outs), 64'(9'b1_0000_0000));
    repeat (2) @(negedge clk);
    #1;
    rel   = cycle_count;
    base  = latch_count;
    reset = 1'b1;
    waitLatches(base + 16, "p3_restart_end");
    checkOutput("p3_first_latch_cycle", 64'(latch_cycles[base % 512]),
                64'(rel + FIRST_LATCH));
    checkFrame(base, 16'h0000, 16'h0000, 16'h0000, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
